abs_stim_sequencer: RTL and testbench
=====================================

Name: abs_stim_sequencer

Overview:
- Stimulus-and-response engine for the a/b/sel → y_comb/y_mux/q_dff example top. It sits on the opposite side of that interface, driving a, b and sel and consuming the three responses.
- On a start pulse it steps through all 8 {sel,b,a} vectors and holds each one for a programmable number of cycles.
- At the end of each hold it samples the three responses into a MISR signature.
- It reports completion with a one-cycle done pulse and a held sig_valid flag.

Parameters:
- HOLD_W, 8: width of the hold_cycles input.
- SIG_W, 16: signature width; must be ≥ 4.
- POLY, 16'h1021: MISR feedback polynomial, truncated to SIG_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- hold_cycles  in  HOLD_W  cycles each vector is held; captured at start.
- a  out  1  stimulus bit 0 of the vector index.
- b  out  1  stimulus bit 1 of the vector index.
- sel  out  1  stimulus bit 2 of the vector index.
- y_comb  in  1  response from the combinational path.
- y_mux  in  1  response from the mux path.
- q_dff  in  1  response from the registered path (1-cycle latency).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the run completes.
- sig_valid  out  1  high after done, until the next accepted start.
- signature  out  SIG_W  MISR result.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs and all state are 0; FSM in IDLE.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1: capture H = max(hold_cycles, 2); clear idx, hold counter and signature; clear sig_valid; go to DRIVE.
  - Minimum H of 2 guarantees q_dff has settled before sampling.
- DRIVE:
  - {sel,b,a} = vec(idx) and busy=1, both visible the cycle after start is accepted.
  - The hold counter counts 1..H-1; on reaching H-1, go to SAMPLE.
- SAMPLE (one cycle, stimulus still held, so each vector is driven for exactly H cycles):
  - r = {y_comb, y_mux, q_dff} zero-extended to SIG_W.
  - signature ← (signature << 1) ^ (signature[SIG_W-1] ? POLY : 0) ^ r.
  - If idx==7 go to DONE; otherwise idx+1, reset the hold counter, go to DRIVE.
- DONE (one cycle): done=1, busy drops to 0, sig_valid=1; go to IDLE.
  - Stimulus returns to 0 in DONE.
  - signature holds its value until the next accepted start.
- Run length: start accepted at cycle 0 → done high at cycle 8·H+1.
- Start while busy or in DONE: ignored, no effect.
- Start high in the IDLE cycle immediately after DONE: a new run is accepted.
- hold_cycles changes mid-run: no effect; H is captured at start.
- hold_cycles = 0 or 1: treated as 2.
- Vector counter: idx is 3 bits; the terminal decision is made on idx==7, so there is no wrap.
- rst mid-run: immediate return to reset values; the partial signature is discarded.
- vec(idx) = idx (binary order) by default.

Optional Feature:
- Macro: STIM_GRAY_EN.
- Defined: vec(idx) = idx ^ (idx >> 1) (Gray order), so exactly one of a/b/sel toggles between consecutive vectors. This is for observing single-input transitions on the scope/LEDs. The signature then reflects the Gray visiting order.
- Undefined: binary order.
- FSM, timing and ports are identical in both builds.

Decomposition:
- Package abs_stim_pkg:
  - state enum typedef (IDLE, DRIVE, SAMPLE, DONE);
  - localparam MIN_HOLD = 2;
  - localparam NUM_VEC = 8;
  - function vec_of(idx), containing the STIM_GRAY_EN selection.
- One sub-module, abs_misr:
  - parameters SIG_W, POLY;
  - ports clk, rst, clr, en, din[2:0], sig.
- The FSM, hold counter and vector counter stay in abs_stim_sequencer.

Test Plan:
- Default build, hold_cycles=4, responses tied 0, start pulse → {sel,b,a} steps 000..111, 4 cycles each; busy for 32 cycles; done at cycle 33; signature=0x0000; sig_valid=1.
- hold_cycles=3, y_comb=1, y_mux=0, q_dff=0 → signature=0x03FC after done; done exactly at cycle 25.
- hold_cycles=0 and then hold_cycles=1 → each vector held 2 cycles; done at cycle 17.
- Start re-pulsed at cycles 5 and 10 of a run → ignored: single done, no timing change. A start in the IDLE cycle right after DONE → new run begins, sig_valid clears.
- rst asserted at cycle 12 of a run, asynchronously mid-cycle → all outputs 0 immediately; a subsequent start gives a full correct run.
- STIM_GRAY_EN build, hold_cycles=2 → vectors 000,001,011,010,110,111,101,100; exactly one stimulus bit toggles per step.

Source files
------------

// File: rtl/abs_stim_pkg.sv
// Shared types and helpers for the a/b/sel stimulus sequencer.
// Build option: define STIM_GRAY_EN to visit the vectors in Gray order.
package abs_stim_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_t;

    localparam int unsigned MIN_HOLD = 2;
    localparam int unsigned NUM_VEC  = 8;

    // Maps the vector counter to the {sel,b,a} pattern driven for that step.
    function automatic logic [2:0] vec_of(input logic [2:0] idx);
`ifdef STIM_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

endpackage

// File: rtl/abs_misr.sv
// Multiple-input signature register folding 3 response bits per enabled cycle.
module abs_misr #(
    parameter int unsigned     SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_d;

    always_comb begin
        w_sig_d = r_sig;
        if (clr) begin
            w_sig_d = '0;
        end else if (en) begin
            w_sig_d = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-3){1'b0}}, din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else begin
            r_sig <= w_sig_d;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/abs_stim_sequencer.sv
// Steps {sel,b,a} through all 8 vectors, holding each H cycles, and MISR-compacts the responses.
// Build option: STIM_GRAY_EN selects Gray visiting order (see abs_stim_pkg::vec_of).
module abs_stim_sequencer #(
    parameter int unsigned      HOLD_W = 8,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              a,
    output logic              b,
    output logic              sel,
    input  logic              y_comb,
    input  logic              y_mux,
    input  logic              q_dff,
    output logic              busy,
    output logic              done,
    output logic              sig_valid,
    output logic [SIG_W-1:0]  signature
);

    import abs_stim_pkg::*;

    state_t            r_state;
    state_t            w_state_d;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_d;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_d;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_d;
    logic              w_accept;
    logic              w_misr_en;
    logic              w_busy_d;
    logic              w_sig_valid_d;
    logic              r_busy;
    logic              r_done;
    logic              r_sig_valid;
    logic [2:0]        r_vec;
    logic [HOLD_W-1:0] w_hold_eff;

    assign w_hold_eff = (hold_cycles < HOLD_W'(MIN_HOLD)) ? HOLD_W'(MIN_HOLD) : hold_cycles;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_hold_d  = r_hold;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        w_misr_en = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_hold_d  = w_hold_eff;
                    w_idx_d   = '0;
                    w_cnt_d   = HOLD_W'(1);
                    w_state_d = StDrive;
                end
            end
            StDrive: begin
                // The SAMPLE cycle is the H-th cycle of the vector.
                if (r_cnt == r_hold - HOLD_W'(1)) begin
                    w_state_d = StSample;
                end else begin
                    w_cnt_d = r_cnt + HOLD_W'(1);
                end
            end
            StSample: begin
                w_misr_en = 1'b1;
                if (r_idx == 3'(NUM_VEC - 1)) begin
                    w_state_d = StDone;
                end else begin
                    w_idx_d   = r_idx + 3'd1;
                    w_cnt_d   = HOLD_W'(1);
                    w_state_d = StDrive;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_busy_d      = (w_state_d == StDrive) || (w_state_d == StSample);
    assign w_sig_valid_d = w_accept ? 1'b0 : ((w_state_d == StDone) ? 1'b1 : r_sig_valid);

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sig_valid <= 1'b0;
            r_vec       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_idx       <= w_idx_d;
            r_hold      <= w_hold_d;
            r_cnt       <= w_cnt_d;
            r_busy      <= w_busy_d;
            r_done      <= (w_state_d == StDone);
            r_sig_valid <= w_sig_valid_d;
            r_vec       <= w_busy_d ? vec_of(w_idx_d) : 3'b000;
        end
    end

    abs_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (w_misr_en),
        .din ({y_comb, y_mux, q_dff}),
        .sig (signature)
    );

    assign {sel, b, a} = r_vec;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sig_valid   = r_sig_valid;

endmodule

// File: tb/tb_abs_stim_sequencer.sv
// Randomized self-checking bench for abs_stim_sequencer; responses come from per-vector tables.
module tb_abs_stim_sequencer;

    localparam logic [15:0] POLY = 16'h1021;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  hold_cycles = 8'd0;
    logic        a, b, sel;
    logic        y_comb, y_mux;
    logic        q_dff = 1'b0;
    logic        busy, done, sig_valid;
    logic [15:0] signature;

    logic [7:0]  t_comb = 8'h00;
    logic [7:0]  t_mux  = 8'h00;
    logic [7:0]  t_dff  = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Stand-in for the example top: two combinational responses and one registered one.
    assign y_comb = t_comb[{sel, b, a}];
    assign y_mux  = t_mux[{sel, b, a}];
    always @(posedge clk) q_dff <= t_dff[{sel, b, a}];

    abs_stim_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .a           (a),
        .b           (b),
        .sel         (sel),
        .y_comb      (y_comb),
        .y_mux       (y_mux),
        .q_dff       (q_dff),
        .busy        (busy),
        .done        (done),
        .sig_valid   (sig_valid),
        .signature   (signature)
    );

    function automatic logic [2:0] order_of(input int k);
        logic [2:0] kk;
        kk = 3'(k);
`ifdef STIM_GRAY_EN
        return kk ^ (kk >> 1);
`else
        return kk;
`endif
    endfunction

    // One full run: start (unless already pending), then check every cycle through the idle cycle.
    task automatic do_run(input int h, input bit preset_start, input bit poke_starts,
                          input bit jitter_hold, input bit chain_next);
        int          he;
        int          last;
        logic [15:0] part [9];
        logic [2:0]  v;
        logic [2:0]  exp_vec;
        logic [2:0]  got_vec;
        logic [2:0]  prev_vec;
        logic        exp_busy;
        logic        exp_done;
        he = (h < 2) ? 2 : h;
        last = 8 * he + 1;
        part[0] = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            v = order_of(k);
            part[k+1] = (part[k] << 1) ^ (part[k][15] ? POLY : 16'h0000)
                        ^ {13'b0, t_comb[v], t_mux[v], t_dff[v]};
        end
        if (!preset_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        hold_cycles = 8'(h);
        @(posedge clk);
        #1 start = 1'b0;
        prev_vec = 3'b000;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_busy = (c < last);
            exp_done = (c == last);
            exp_vec  = exp_busy ? order_of((c - 1) / he) : 3'b000;
            got_vec  = {sel, b, a};
            n_checks++;
            if (busy !== exp_busy) $display("FAIL busy h=%0d c=%0d got=%0b exp=%0b", h, c, busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (done !== exp_done) $display("FAIL done h=%0d c=%0d got=%0b exp=%0b", h, c, done, exp_done);
            else n_pass++;
            n_checks++;
            if (got_vec !== exp_vec) $display("FAIL vec h=%0d c=%0d got=%0b exp=%0b", h, c, got_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (sig_valid !== exp_done)
                $display("FAIL sig_valid h=%0d c=%0d got=%0b exp=%0b", h, c, sig_valid, exp_done);
            else n_pass++;
            if ((c - 1) % he == 0) begin
                n_checks++;
                if (signature !== part[(c-1)/he])
                    $display("FAIL signature h=%0d c=%0d got=%04h exp=%04h", h, c, signature, part[(c-1)/he]);
                else n_pass++;
`ifdef STIM_GRAY_EN
                if (c > 1 && c < last) begin
                    n_checks++;
                    if ($countones(got_vec ^ prev_vec) != 1)
                        $display("FAIL gray_step c=%0d got=%0b prev=%0b exp=one_bit", c, got_vec, prev_vec);
                    else n_pass++;
                end
`endif
            end
            prev_vec = got_vec;
            start = poke_starts && (c == 5 || c == 10);
            if (jitter_hold) hold_cycles = 8'($urandom);
            if (c == last && chain_next) start = 1'b1;
        end
        // Idle cycle after DONE; a start held through DONE must not have taken effect yet.
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after h=%0d got=%0b%0b exp=00", h, busy, done);
        else n_pass++;
        n_checks++;
        if (sig_valid !== 1'b1) $display("FAIL sig_valid_hold h=%0d got=%0b exp=1", h, sig_valid);
        else n_pass++;
        n_checks++;
        if (signature !== part[8])
            $display("FAIL sig_hold h=%0d got=%04h exp=%04h", h, signature, part[8]);
        else n_pass++;
        n_checks++;
        if ({sel, b, a} !== 3'b000) $display("FAIL vec_idle h=%0d got=%0b exp=000", h, {sel, b, a});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, sig_valid, sel, b, a} !== 6'b0 || signature !== 16'h0)
            $display("FAIL reset_in got=%0b%0b%0b %0b %04h exp=000 000 0000",
                     busy, done, sig_valid, {sel, b, a}, signature);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, sig_valid, sel, b, a} !== 6'b0 || signature !== 16'h0)
            $display("FAIL reset_idle got=%0b%0b%0b %0b %04h exp=000 000 0000",
                     busy, done, sig_valid, {sel, b, a}, signature);
        else n_pass++;
    endtask

    task automatic test_all_zero();
        t_comb = 8'h00; t_mux = 8'h00; t_dff = 8'h00;
        do_run(4, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (signature !== 16'h0000) $display("FAIL zero_sig got=%04h exp=0000", signature);
        else n_pass++;
    endtask

    task automatic test_comb_only();
        t_comb = 8'hFF; t_mux = 8'h00; t_dff = 8'h00;
        do_run(3, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (signature !== 16'h03FC) $display("FAIL comb_sig got=%04h exp=03fc", signature);
        else n_pass++;
    endtask

    task automatic test_min_hold();
        t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
        do_run(0, 1'b0, 1'b0, 1'b0, 1'b0);
        t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
        do_run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
        do_run(5, 1'b0, 1'b1, 1'b1, 1'b1);
        t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
        do_run(2, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        t_comb = 8'hFF; t_mux = 8'h5A; t_dff = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        hold_cycles = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sig_valid, sel, b, a} !== 6'b0 || signature !== 16'h0)
            $display("FAIL reset_mid got=%0b%0b%0b %0b %04h exp=000 000 0000",
                     busy, done, sig_valid, {sel, b, a}, signature);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
        do_run(3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            t_comb = 8'($urandom); t_mux = 8'($urandom); t_dff = 8'($urandom);
            do_run(int'($urandom_range(2, 7)), 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_comb_only();
        test_min_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
